// File: rtl/m_wb_gpio.sv
`timescale 1ns/1ps
// m_wb_gpio: Wishbone-classic GPIO slave with synchronised inputs and a wait-state ACK handshake.
// Define MIDGETV_GPIO_EDGECAPTURE_EN to add sticky rising-edge capture, MASK and irq_o.
module m_wb_gpio #(
  parameter int              NOUT       = 4,
  parameter int              NIN        = 1,
  parameter int              SYNCSTAGES = 2,
  parameter int              WAITSTATES = 0,
  parameter logic [NOUT-1:0] OUTRESET   = '0
) (
  input  logic            CLK_I,
  input  logic            RST_N_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [1:0]      ADR_I,
  input  logic [3:0]      SEL_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  output logic            ACK_O,
  input  logic [NIN-1:0]  gpio_in,
  output logic [NOUT-1:0] gpio_out,
  output logic            irq_o
);

  localparam logic [2:0] WS = 3'(WAITSTATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [NOUT-1:0] out_q, out_d;
  logic [NIN-1:0]  sync_q [SYNCSTAGES];
  logic [NIN-1:0]  sync_d [SYNCSTAGES];
  logic            req, commit, wr;
  logic [31:0]     wmask, rdata;
  logic [NIN-1:0]  in_w;
  logic            unused_bits;

`ifdef MIDGETV_GPIO_EDGECAPTURE_EN
  logic [NIN-1:0]  prev_q, prev_d;
  logic [NIN-1:0]  edge_q, edge_d;
  logic [NIN-1:0]  mask_q, mask_d;
  logic [NIN-1:0]  rise, clr;
  logic            irq_q, irq_d;
`endif

  assign req         = CYC_I & STB_I;
  assign wr          = commit & WE_I;
  assign wmask       = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
  assign in_w        = sync_q[SYNCSTAGES-1];
  assign unused_bits = ^{DAT_I, wmask};

  assign ACK_O    = ack_q;
  assign DAT_O    = dat_q;
  assign gpio_out = out_q;

  // Handshake: commit marks the edge that raises ACK_O; writes and read capture happen there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d = WS;
          if (WS == 3'd0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 3'd1) begin
          state_d = S_ACK;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read mux sees the registers before this transfer's write lands.
  always_comb begin
    rdata = '0;
    case (ADR_I)
      2'd0: rdata[NOUT-1:0] = out_q;
      2'd1: rdata[NIN-1:0]  = in_w;
`ifdef MIDGETV_GPIO_EDGECAPTURE_EN
      2'd2: rdata[NIN-1:0]  = edge_q;
      2'd3: rdata[NIN-1:0]  = mask_q;
`endif
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ack_d = commit;
    dat_d = commit ? rdata : '0;
    out_d = out_q;
    if (wr && ADR_I == 2'd0) begin
      out_d = (out_q & ~wmask[NOUT-1:0]) | (DAT_I[NOUT-1:0] & wmask[NOUT-1:0]);
    end
  end

  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNCSTAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      out_q   <= OUTRESET;
      for (int i = 0; i < SYNCSTAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      for (int i = 0; i < SYNCSTAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

`ifdef MIDGETV_GPIO_EDGECAPTURE_EN
  // A rising edge in the same cycle as a write-1-to-clear keeps the flag set.
  always_comb begin
    rise   = in_w & ~prev_q;
    clr    = '0;
    mask_d = mask_q;
    if (wr && ADR_I == 2'd2) begin
      clr = DAT_I[NIN-1:0] & wmask[NIN-1:0];
    end
    if (wr && ADR_I == 2'd3) begin
      mask_d = (mask_q & ~wmask[NIN-1:0]) | (DAT_I[NIN-1:0] & wmask[NIN-1:0]);
    end
    prev_d = in_w;
    edge_d = (edge_q & ~clr) | rise;
    irq_d  = |(edge_q & mask_q);
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      prev_q <= '0;
      edge_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      edge_q <= edge_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_m_wb_gpio.sv
`timescale 1ns/1ps
// tb_m_wb_gpio: table-driven bench with an ACK-side scoreboard for two m_wb_gpio instances (0 and 3 wait states).
module tb_m_wb_gpio;

`ifdef MIDGETV_GPIO_EDGECAPTURE_EN
  localparam logic [31:0] EC = 32'd1;
`else
  localparam logic [31:0] EC = 32'd0;
`endif

  localparam int WSV [2] = '{0, 3};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc, stb, we, gin;
  logic [1:0]  adr   [2];
  logic [3:0]  sel   [2];
  logic [31:0] dat_i [2];
  logic        ack0, ack1, irq0, irq1;
  logic [31:0] dato0, dato1;
  logic [3:0]  gout0, gout1;
  logic [1:0]  ack;

  assign ack = {ack1, ack0};

  always #5 clk = ~clk;

  m_wb_gpio #(.NOUT(4), .NIN(1), .SYNCSTAGES(2), .WAITSTATES(0), .OUTRESET(4'b1010)) dut0 (
    .CLK_I(clk), .RST_N_I(rst_n), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]),
    .ADR_I(adr[0]), .SEL_I(sel[0]), .DAT_I(dat_i[0]), .DAT_O(dato0), .ACK_O(ack0),
    .gpio_in(gin[0]), .gpio_out(gout0), .irq_o(irq0));

  m_wb_gpio #(.NOUT(4), .NIN(1), .SYNCSTAGES(2), .WAITSTATES(3), .OUTRESET(4'b0000)) dut3 (
    .CLK_I(clk), .RST_N_I(rst_n), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]),
    .ADR_I(adr[1]), .SEL_I(sel[1]), .DAT_I(dat_i[1]), .DAT_O(dato1), .ACK_O(ack1),
    .gpio_in(gin[1]), .gpio_out(gout1), .irq_o(irq1));

  typedef struct {
    int          inst;
    logic [31:0] dat;
    bit          chk;
    logic [3:0]  out;
    int          lat;
  } exp_t;

  typedef struct {
    int          inst;
    bit          w;
    logic [1:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] ed;
    bit          cd;
    logic [3:0]  eo;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] get_dat(input int i);
    return (i == 0) ? dato0 : dato1;
  endfunction

  function automatic logic [3:0] get_out(input int i);
    return (i == 0) ? gout0 : gout1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; drives one transfer and checks it when ACK arrives.
  task automatic xfer(input int i, input bit w, input logic [1:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] ed, input bit cd,
                      input logic [3:0] eo, input string name);
    exp_t e;
    int   n;
    e.inst = i; e.dat = ed; e.chk = cd; e.out = eo; e.lat = WSV[i] + 1;
    sb.push_back(e);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; sel[i] = s; dat_i[i] = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack[i] && n < 20);
    e = sb.pop_front();
    check({name, " ack"}, {31'd0, ack[i]}, 32'd1);
    check({name, " lat"}, n, e.lat);
    if (e.chk) check({name, " dat"}, get_dat(e.inst), e.dat);
    check({name, " out"}, {28'd0, get_out(e.inst)}, {28'd0, e.out});
    cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    @(posedge clk); #1;
    check({name, " ack_pulse"}, {31'd0, ack[i]}, 32'd0);
    check({name, " dat_idle"}, get_dat(i), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; gin = '0;
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; sel[i] = '0; dat_i[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst gout0", {28'd0, gout0}, 32'hA);
    check("rst gout3", {28'd0, gout1}, 32'h0);
    check("rst ack",   {30'd0, ack},   32'd0);
    check("rst dat0",  dato0,          32'd0);
    check("rst irq",   {30'd0, irq1, irq0}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Both instances mid-transfer, then reset lands between clock edges.
    cyc = 2'b11; stb = 2'b11; we = 2'b11;
    adr[0] = 2'd0; sel[0] = 4'b0001; dat_i[0] = 32'h5;
    adr[1] = 2'd0; sel[1] = 4'b0001; dat_i[1] = 32'hF;
    @(posedge clk); #1;
    check("ws0 ack_lat1", {31'd0, ack0}, 32'd1);
    check("ws0 commit",   {28'd0, gout0}, 32'h5);
    rst_n = 1'b0;
    #1;
    check("async ack0", {31'd0, ack0}, 32'd0);
    check("async gout0", {28'd0, gout0}, 32'hA);
    check("async dat0", dato0, 32'd0);
    check("async gout3", {28'd0, gout1}, 32'h0);
    cyc = '0; stb = '0; we = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back('{0, 0, 2'd0, 4'hF, 32'h0,        32'hA, 1, 4'hA});
    tbl.push_back('{0, 1, 2'd0, 4'h1, 32'h5,        32'h0, 0, 4'h5});
    tbl.push_back('{0, 0, 2'd0, 4'hF, 32'h0,        32'h5, 1, 4'h5});
    tbl.push_back('{0, 1, 2'd0, 4'h0, 32'hFFFFFFFF, 32'h0, 0, 4'h5});
    tbl.push_back('{0, 0, 2'd0, 4'hF, 32'h0,        32'h5, 1, 4'h5});
    tbl.push_back('{0, 1, 2'd0, 4'h2, 32'h00000F00, 32'h0, 0, 4'h5});
    tbl.push_back('{0, 1, 2'd0, 4'h1, 32'hFFFFFFF3, 32'h0, 0, 4'h3});
    tbl.push_back('{0, 0, 2'd0, 4'hF, 32'h0,        32'h3, 1, 4'h3});
    tbl.push_back('{0, 1, 2'd1, 4'hF, 32'hFF,       32'h0, 0, 4'h3});
    tbl.push_back('{0, 0, 2'd1, 4'hF, 32'h0,        32'h0, 1, 4'h3});
    tbl.push_back('{0, 1, 2'd2, 4'hF, 32'hFF,       32'h0, 0, 4'h3});
    tbl.push_back('{0, 0, 2'd2, 4'hF, 32'h0,        32'h0, 1, 4'h3});
    tbl.push_back('{0, 1, 2'd3, 4'hF, 32'hFF,       32'h0, 0, 4'h3});
    tbl.push_back('{0, 0, 2'd3, 4'hF, 32'h0,        EC,    1, 4'h3});
    tbl.push_back('{0, 1, 2'd3, 4'hF, 32'h0,        32'h0, 0, 4'h3});
    tbl.push_back('{1, 0, 2'd0, 4'hF, 32'h0,        32'h0, 1, 4'h0});
    tbl.push_back('{1, 1, 2'd0, 4'h1, 32'h6,        32'h0, 0, 4'h6});
    tbl.push_back('{1, 0, 2'd0, 4'hF, 32'h0,        32'h6, 1, 4'h6});
    tbl.push_back('{1, 0, 2'd1, 4'hF, 32'h0,        32'h0, 1, 4'h6});

    foreach (tbl[k]) begin
      xfer(tbl[k].inst, tbl[k].w, tbl[k].a, tbl[k].s, tbl[k].d, tbl[k].ed, tbl[k].cd, tbl[k].eo,
           $sformatf("vec%0d", k));
    end

    // Abort from WAIT: strobe dropped after two cycles, no ACK and no write.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 2'd0; sel[1] = 4'h1; dat_i[1] = 32'h9;
    repeat (2) @(posedge clk);
    #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    begin
      int acks = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (ack1) acks++;
      end
      check("abort no_ack", acks, 0);
    end
    check("abort gout3", {28'd0, gout1}, 32'h6);

    // Synchroniser depth: a pin change is not visible to a read sampled one edge later.
    repeat (4) @(posedge clk);
    #1 gin[0] = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 2'd1, 4'hF, 32'h0, 32'h0, 1, 4'h3, "sync_t+1");
    gin[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 gin[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    xfer(0, 0, 2'd1, 4'hF, 32'h0, 32'h1, 1, 4'h3, "sync_t+2");
    xfer(0, 0, 2'd1, 4'hF, 32'h0, 32'h1, 1, 4'h3, "sync_hold");
    gin[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

`ifdef MIDGETV_GPIO_EDGECAPTURE_EN
    xfer(0, 1, 2'd2, 4'h1, 32'h1, 32'h0, 0, 4'h3, "edge_clr0");
    xfer(0, 1, 2'd3, 4'h1, 32'h1, 32'h0, 0, 4'h3, "mask_set");
    check("irq idle", {31'd0, irq0}, 32'd0);
    gin[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("irq before", {31'd0, irq0}, 32'd0);
    @(posedge clk); #1;
    check("irq rise", {31'd0, irq0}, 32'd1);
    gin[0] = 1'b0;
    xfer(0, 0, 2'd2, 4'hF, 32'h0, 32'h1, 1, 4'h3, "edge_set");
    xfer(0, 1, 2'd2, 4'h1, 32'h1, 32'h0, 0, 4'h3, "edge_w1c");
    check("irq fall", {31'd0, irq0}, 32'd0);
    xfer(0, 0, 2'd2, 4'hF, 32'h0, 32'h0, 1, 4'h3, "edge_cleared");
    repeat (4) @(posedge clk);
    #1 gin[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 gin[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    xfer(0, 0, 2'd2, 4'hF, 32'h0, 32'h1, 1, 4'h3, "edge_sticky");
    gin[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    xfer(0, 1, 2'd2, 4'h1, 32'h1, 32'h0, 0, 4'h3, "edge_clr_race");
    xfer(0, 0, 2'd2, 4'hF, 32'h0, 32'h1, 1, 4'h3, "edge_race_wins");
    gin[0] = 1'b0;
`else
    xfer(0, 1, 2'd3, 4'hF, 32'hFF, 32'h0, 0, 4'h3, "off_mask_wr");
    xfer(0, 0, 2'd3, 4'hF, 32'h0,  32'h0, 1, 4'h3, "off_mask_rd");
    for (int k = 0; k < 10; k++) begin
      gin[0] = ~gin[0];
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("off_irq%0d", k), {30'd0, irq1, irq0}, 32'd0);
    end
    xfer(0, 0, 2'd2, 4'hF, 32'h0, 32'h0, 1, 4'h3, "off_edge_rd");
`endif

    check("sb empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m_wb_gpio.md
Name: m_wb_gpio

Overview:
- Parametrised Wishbone-classic slave GPIO block for midgetv board tops.
- Replaces ad-hoc board glue: the hardwired LED latch on write, the single-bit RX input synchroniser, and the ACK tied to STB.
- Provides NOUT output pins, NIN synchronised input pins with readback, a configurable wait-state ACK handshake, and optional sticky edge capture with an interrupt suitable for the core's meip input.

Parameters:
- NOUT, 4: number of output pins, 1..32.
- NIN, 1: number of input pins, 1..32.
- SYNCSTAGES, 2: input synchroniser depth, 2..4.
- WAITSTATES, 0: extra cycles inserted before ACK_O, 0..7.
- OUTRESET, 0: reset value of the output register, NOUT bits.

Ports:
- CLK_I  in  1  system clock
- RST_N_I  in  1  asynchronous active-low reset
- CYC_I  in  1  Wishbone cycle
- STB_I  in  1  Wishbone strobe
- WE_I  in  1  write enable
- ADR_I  in  2  word address (core ADR_O[3:2])
- SEL_I  in  4  byte enables
- DAT_I  in  32  write data
- DAT_O  out  32  read data
- ACK_O  out  1  transfer acknowledge
- gpio_in  in  NIN  asynchronous input pins
- gpio_out  out  NOUT  registered output pins
- irq_o  out  1  interrupt request, active-high

Behaviour:
- Clock and reset: one clock, CLK_I. Reset is asynchronous and active-low on RST_N_I.
- Reset values: gpio_out=OUTRESET, ACK_O=0, DAT_O=0, irq_o=0, synchroniser flops=0, EDGE=0, MASK=0. The state machine resets to IDLE and its wait counter to 0.
- Register map (ADR_I):
  - 0 OUT: read/write.
  - 1 IN: read-only, synchronised value; writes ignored.
  - 2 EDGE: write-1-to-clear.
  - 3 MASK: read/write.
- Unimplemented high bits read 0.
- Handshake state machine IDLE -> WAIT -> ACK -> IDLE:
  - IDLE: if CYC_I&STB_I, load the counter with WAITSTATES. Go to ACK if WAITSTATES=0, else to WAIT.
  - WAIT: decrement the counter. Go to ACK when it reaches 1. If CYC_I&STB_I drops, abort to IDLE with no side effects.
  - ACK: ACK_O=1 for exactly one cycle, then IDLE. ACK_O is never high on two consecutive cycles.
- Latency: ACK_O rises WAITSTATES+1 cycles after the first cycle with CYC_I&STB_I high.
- Commit and read timing:
  - A write commits on the same edge that raises ACK_O.
  - DAT_O is registered on that edge and is valid while ACK_O=1. DAT_O is 0 otherwise.
  - A read returns the pre-write value.
- SEL_I gates writes per byte for OUT, MASK and EDGE. Bits beyond NOUT/NIN are ignored.
- Synchroniser:
  - gpio_in passes through SYNCSTAGES flops. IN is the last stage.
  - A change at the pin is readable SYNCSTAGES cycles later.
- gpio_out is driven directly from the OUT register, with no further logic.

Optional Feature:
- Macro: MIDGETV_GPIO_EDGECAPTURE_EN.
- Defined:
  - A rising edge is detected when IN bit is 1 and its previous-cycle sample is 0.
  - A detected edge sets the sticky EDGE bit.
  - Writing 1 to an EDGE bit clears it. An edge arriving in the same cycle as the clear wins, so the bit stays 1.
  - irq_o is registered: irq_o <= |(EDGE & MASK), one cycle after the flag or mask changes.
- Undefined:
  - EDGE and MASK are not implemented; addresses 2 and 3 read 0 and writes are acknowledged but ignored.
  - irq_o is tied to 0.
  - The handshake is unchanged.

Test Plan:
- Reset and defaults: OUTRESET=4'b1010, assert RST_N_I=0 mid-transfer -> gpio_out=4'b1010, ACK_O=0 immediately with no clock edge. After release, a read of ADR 0 returns 0x0000000A.
- Write/read latency: WAITSTATES=0, write 0x5 to ADR 0 with SEL=0001 -> ACK_O high exactly 1 cycle after STB, gpio_out=4'b0101 in that cycle. WAITSTATES=3 -> ACK at cycle 4, single-cycle pulse.
- Byte masking and abort: write 0xFFFFFFFF with SEL=0000 -> OUT unchanged. WAITSTATES=3 with STB dropped in WAIT -> no ACK, OUT unchanged.
- Synchroniser: SYNCSTAGES=2, gpio_in[0] 0->1 at cycle t -> read of ADR 1 returns 1 from t+2 onward and 0 before.
- Edge capture (macro on):
  - Set MASK=1, pulse gpio_in[0] -> EDGE[0]=1 and irq_o=1 one cycle later.
  - Write 1 to EDGE -> irq_o falls.
  - Clear coinciding with a new edge -> EDGE[0] stays 1.
- Macro off: ADR 2/3 read 0 after a write of 0xFF, and irq_o stays 0 while gpio_in toggles.
